mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares the single external SPI memory controller (mem_external) between the instruction-fetch port and the load/store port of the RV32E core.
- Selects one requester, latches its command and drives the controller's start/done handshake.
- Right-aligns partial-width read data and returns it with a one-cycle done pulse.
- A watchdog aborts transactions that never complete.

Parameters:
- ADDR_W, 25, address width: bit 24 selects RAM (1) or flash (0).
- TIMEOUT_CYCLES, 200, maximum cycles that mem_start_request may stay high before the transaction is aborted (must be >= 70).
- TMO_W, 8, width of the watchdog counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level; 4-byte read.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  32  fetched word.
- if_done  out  1  one-cycle completion pulse.
- ls_req  in  1  load/store request, level.
- ls_addr  in  ADDR_W  load/store address.
- ls_is_write  in  1  1 = store.
- ls_num_bytes  in  3  1, 2 or 4; any other value is treated as 4.
- ls_wdata  in  32  store data, right-aligned.
- ls_rdata  out  32  load data, zero-extended and right-aligned.
- ls_done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with a done pulse when that transaction timed out.
- mem_num_bytes  out  3  to the controller.
- mem_target_address  out  ADDR_W  to the controller.
- mem_is_write  out  1  to the controller.
- mem_write_value  out  32  to the controller.
- mem_start_request  out  1  to the controller.
- mem_fetched_value  in  32  from the controller.
- mem_request_done  in  1  from the controller.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0. last_grant=LS, so the first contention goes to IF. Asserting reset mid-transaction drops mem_start_request immediately, which aborts the controller.
- States:
  - IDLE -> ISSUE when any request is pending.
  - ISSUE -> RESPOND on mem_request_done=1, or when the watchdog count reaches TIMEOUT_CYCLES.
  - RESPOND -> IDLE unconditionally.
- Grant is decided only in IDLE:
  - Only one of if_req/ls_req high: grant it.
  - Both high: grant the port that is not last_grant.
  - last_grant updates on every grant.
- On grant (IDLE edge), latch the command:
  - IF grant: address=if_addr, num_bytes=4, is_write=0, write_value=0.
  - LS grant: address=ls_addr, num_bytes=ls_num_bytes, is_write=ls_is_write, write_value=ls_wdata.
- Outputs during ISSUE:
  - mem_* outputs come from the latched registers and stay stable for the whole of ISSUE.
  - Changes on the requester inputs after the grant are ignored.
- mem_start_request: registered; 1 exactly while state=ISSUE.
- Latency:
  - Request sampled in IDLE at edge N gives mem_start_request=1 from N+1.
  - mem_request_done sampled at edge M gives RESPOND from M+1: done=1, rdata valid, mem_start_request=0.
  - mem_start_request stays low for at least 2 cycles (RESPOND and IDLE), so the controller sees start=0 on at least one falling edge and returns to idle.
- Read alignment, captured at the ISSUE->RESPOND edge from mem_fetched_value (F):
  - 1 byte: {24'b0, F[31:24]}.
  - 2 bytes: {16'b0, F[31:16]}.
  - 4 bytes: F.
  - Stale bits below the valid bytes are discarded.
  - Writes return rdata=0.
- rdata holding: if_rdata/ls_rdata hold their value until the next completion on the same port.
- Watchdog: counter cleared on grant, increments each ISSUE cycle, saturates.
  - Timeout: move to RESPOND, pulse done and err together, rdata=0.
  - If mem_request_done arrives on the same cycle as the timeout, done has priority and err=0.
- Requester contract:
  - Deassert req on the cycle after done is seen.
  - A req still high in the following IDLE is treated as a new request.
  - Because the arbiter grants only in IDLE, a held LS req cannot starve IF, and vice versa.

Decomposition:
- Shared package mem_pkg holds:
  - State encodings ST_IDLE/ST_ISSUE/ST_RESPOND as one-hot 3'b001/010/100, matching the controller's style.
  - GRANT_IF/GRANT_LS.
  - The RAM_SEL_BIT=24 constant.
- One natural sub-module, mem_read_align: the combinational byte-count aligner, reusable by a later cache fill path.
- The rest is a single module.

Test Plan:
- Single fetch: if_req=1, if_addr=0x000100, bench controller returns done after 66 cycles with F=0xDDCCBBAA -> mem_num_bytes=4, mem_is_write=0, if_rdata=0xDDCCBBAA, if_done one cycle, mem_start_request low for >=2 cycles afterwards.
- Byte load from RAM: ls_addr=0x1000010, ls_num_bytes=1, F=0x5A123456 -> mem_target_address bit24=1, ls_rdata=0x0000005A. Halfword with F=0xBEEF9999 -> ls_rdata=0x0000BEEF.
- Store: ls_is_write=1, ls_wdata=0x11223344, ls_num_bytes=4 -> mem_is_write=1, mem_write_value=0x11223344 held through ISSUE, ls_done pulse, ls_rdata=0.
- Contention: if_req and ls_req both high from reset -> grant order IF, LS, IF, LS over four transactions. No port is granted twice in a row while the other is pending.
- Timeout: controller never asserts done -> after TIMEOUT_CYCLES (200) in ISSUE, done and err pulse, rdata=0. Done and timeout on the same cycle -> err=0.
- Reset mid-ISSUE: rst_n low 30 cycles into a transaction -> mem_start_request=0 asynchronously (before the next clock edge), no done pulse. After release, a pending if_req is granted normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter and its helpers: FSM encodings,
// grant identifiers and the RAM/flash address select bit.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_ISSUE   = 3'b010,
    ST_RESPOND = 3'b100
  } state_t;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_LS = 1'b1
  } grant_t;

  localparam int RAM_SEL_BIT = 24;

  // The controller only understands 1, 2 or 4 bytes; anything else becomes a word.
  function automatic logic [2:0] norm_num_bytes(input logic [2:0] n);
    return (n == 3'd1 || n == 3'd2) ? n : 3'd4;
  endfunction

endpackage

// File: rtl/mem_read_align.sv
// Right-aligns the valid bytes of a controller read word; the controller shifts
// bytes in from the top, so stale bits sit below the valid ones.
module mem_read_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_num_bytes,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_num_bytes)
      3'd1:    o_data = {24'b0, i_data[31:24]};
      3'd2:    o_data = {16'b0, i_data[31:16]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the SPI memory controller between instruction fetch and load/store,
// with round-robin grant in IDLE and a watchdog on stuck transactions.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 25,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int TMO_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_is_write,
  input  logic [2:0]        ls_num_bytes,
  input  logic [31:0]       ls_wdata,
  output logic [31:0]       ls_rdata,
  output logic              ls_done,
  output logic              err,
  output logic [2:0]        mem_num_bytes,
  output logic [ADDR_W-1:0] mem_target_address,
  output logic              mem_is_write,
  output logic [31:0]       mem_write_value,
  output logic              mem_start_request,
  input  logic [31:0]       mem_fetched_value,
  input  logic              mem_request_done
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t              r_state;
  state_t              w_nextState;
  grant_t              r_lastGrant;
  grant_t              r_curGrant;
  grant_t              w_grant;
  logic [TMO_W-1:0]    r_tmo;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_numBytes;
  logic                r_isWrite;
  logic [31:0]         r_writeValue;
  logic [31:0]         r_ifRdata;
  logic [31:0]         r_lsRdata;
  logic                r_err;
  logic                w_anyReq;
  logic                w_timeout;
  logic                w_finish;
  logic [31:0]         w_aligned;
  logic [31:0]         w_result;

  assign w_anyReq  = if_req | ls_req;
  assign w_grant   = (ls_req && (!if_req || r_lastGrant == GRANT_IF)) ? GRANT_LS : GRANT_IF;
  assign w_timeout = (r_tmo >= TMO_LAST);
  assign w_finish  = (r_state == ST_ISSUE) && (mem_request_done || w_timeout);

  mem_read_align u_align (
    .i_num_bytes (r_numBytes),
    .i_data      (mem_fetched_value),
    .o_data      (w_aligned)
  );

  // A real completion wins over a coincident timeout; aborted or write transfers return zero.
  assign w_result = (mem_request_done && !r_isWrite) ? w_aligned : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:    if (w_anyReq) w_nextState = ST_ISSUE;
      ST_ISSUE:   if (mem_request_done || w_timeout) w_nextState = ST_RESPOND;
      ST_RESPOND: w_nextState = ST_IDLE;
      default:    w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastGrant  <= GRANT_LS;
      r_curGrant   <= GRANT_IF;
      r_tmo        <= '0;
      r_addr       <= '0;
      r_numBytes   <= '0;
      r_isWrite    <= 1'b0;
      r_writeValue <= '0;
      r_ifRdata    <= '0;
      r_lsRdata    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state == ST_IDLE && w_anyReq) begin
        r_curGrant  <= w_grant;
        r_lastGrant <= w_grant;
        r_tmo       <= '0;
        if (w_grant == GRANT_LS) begin
          r_addr       <= ls_addr;
          r_numBytes   <= norm_num_bytes(ls_num_bytes);
          r_isWrite    <= ls_is_write;
          r_writeValue <= ls_wdata;
        end else begin
          r_addr       <= if_addr;
          r_numBytes   <= 3'd4;
          r_isWrite    <= 1'b0;
          r_writeValue <= '0;
        end
      end
      if (r_state == ST_ISSUE && r_tmo != '1) r_tmo <= r_tmo + TMO_W'(1);
      if (w_finish) begin
        r_err <= !mem_request_done;
        if (r_curGrant == GRANT_IF) r_ifRdata <= w_result;
        else                        r_lsRdata <= w_result;
      end
    end
  end

  assign mem_start_request  = (r_state == ST_ISSUE);
  assign mem_target_address = r_addr;
  assign mem_num_bytes      = r_numBytes;
  assign mem_is_write       = r_isWrite;
  assign mem_write_value    = r_writeValue;
  assign if_done            = (r_state == ST_RESPOND) && (r_curGrant == GRANT_IF);
  assign ls_done            = (r_state == ST_RESPOND) && (r_curGrant == GRANT_LS);
  assign if_rdata           = r_ifRdata;
  assign ls_rdata           = r_lsRdata;
  assign err                = r_err;

endmodule
